// File: rtl/ysyx_25040105_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, owner encoding,
// and default bus widths.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Imported by ysyx_25040105_rr_arb2 and ysyx_25040105_mem_arb.
package ysyx_25040105_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  // One outstanding transaction: idle -> drive request -> wait for response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Which requester owns the in-flight transaction. OWN_LSU is also the
  // round-robin preference after reset.
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_25040105_rr_arb2.sv
// Two-way round-robin grant (IFU vs LSU) with its preference pointer.
// Latency: grants are combinational from valids and pointer; pointer updates one edge after upd_i.
// Backpressure: grants only while en_i is high; pointer holds until a transaction completes.
// Ports: clk/rst; en_i arbitration window; ifu_vld_i/lsu_vld_i requests;
//        upd_i/upd_owner_i completion notice; ifu_gnt_o/lsu_gnt_o one-hot grants.
module ysyx_25040105_rr_arb2
  import ysyx_25040105_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  input  logic   ifu_vld_i,
  input  logic   lsu_vld_i,
  input  logic   upd_i,
  input  owner_e upd_owner_i,
  output logic   ifu_gnt_o,
  output logic   lsu_gnt_o
);

  // pref_q names the requester that wins when both are valid.
  owner_e pref_q, pref_d;

  always_comb begin
    lsu_gnt_o = en_i && lsu_vld_i && (!ifu_vld_i || (pref_q == OWN_LSU));
    ifu_gnt_o = en_i && ifu_vld_i && (!lsu_vld_i || (pref_q == OWN_IFU));
  end

  // The requester just served drops to lower priority.
  always_comb begin
    pref_d = pref_q;
    if (upd_i) begin
      pref_d = (upd_owner_i == OWN_IFU) ? OWN_LSU : OWN_IFU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pref_q <= OWN_LSU;
    end else begin
      pref_q <= pref_d;
    end
  end

endmodule

// File: rtl/ysyx_25040105_mem_arb.sv
// Arbitrates IFU and LSU onto a single memory port, one transaction in flight.
// Latency: accept N, mem request N+1, earliest response N+2 (combinational to owner), next accept N+3.
// Backpressure: requester ready only in IDLE; request held until mem_req_ready; WAIT aborts after TIMEOUT cycles.
// Ports: ifu_* fetch request/response, lsu_* load/store request/response,
//        mem_* registered request fields and single-cycle response pulse.
module ysyx_25040105_mem_arb
  import ysyx_25040105_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  // IFU
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_err,
  // LSU
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  // Memory
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [15:0]         timer_q, timer_d;

  logic                in_idle, in_req, in_wait;
  logic                ifu_gnt, lsu_gnt, accept;
  logic                resp_hit, tmo_hit, done;
  logic [16:0]         wait_cnt;
  logic [DATA_W-1:0]   resp_rdata;

  // Reset is folded into the state decodes so nothing handshakes or pulses
  // during the reset cycle; an abandoned transaction stays silent.
  assign in_idle = (state_q == ST_IDLE) && !rst;
  assign in_req  = (state_q == ST_REQ)  && !rst;
  assign in_wait = (state_q == ST_WAIT) && !rst;

  ysyx_25040105_rr_arb2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .en_i        (in_idle),
    .ifu_vld_i   (ifu_req_valid),
    .lsu_vld_i   (lsu_req_valid),
    .upd_i       (done),
    .upd_owner_i (owner_q),
    .ifu_gnt_o   (ifu_gnt),
    .lsu_gnt_o   (lsu_gnt)
  );

  assign accept = ifu_gnt || lsu_gnt;

  // wait_cnt counts WAIT cycles including the current one, so the abort lands
  // exactly TIMEOUT cycles after the request handshake. A response in that
  // same cycle takes priority.
  assign wait_cnt = {1'b0, timer_q} + 17'd1;
  assign resp_hit = in_wait && mem_resp_valid;
  assign tmo_hit  = in_wait && !mem_resp_valid && (wait_cnt == 17'(TIMEOUT));
  assign done     = resp_hit || tmo_hit;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_REQ;
          owner_d = lsu_gnt ? OWN_LSU : OWN_IFU;
          addr_d  = lsu_gnt ? lsu_addr : ifu_addr;
          // Fetches are always reads with no byte lanes enabled.
          wen_d   = lsu_gnt && lsu_wen;
          wdata_d = lsu_gnt ? lsu_wdata : '0;
          wmask_d = lsu_gnt ? lsu_wmask : '0;
        end
      end
      ST_REQ: begin
        // No abort here: memory may backpressure indefinitely.
        if (mem_req_ready) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
      end
      ST_WAIT: begin
        if (done) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      timer_q <= timer_d;
    end
  end

  assign ifu_req_ready = ifu_gnt;
  assign lsu_req_ready = lsu_gnt;

  assign mem_req_valid = in_req;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // A timeout returns zero data with err set.
  assign resp_rdata = resp_hit ? mem_rdata : '0;

  assign ifu_resp_valid = done && (owner_q == OWN_IFU);
  assign ifu_rdata      = ifu_resp_valid ? resp_rdata : '0;
  assign ifu_err        = ifu_resp_valid && tmo_hit;

  assign lsu_resp_valid = done && (owner_q == OWN_LSU);
  assign lsu_rdata      = lsu_resp_valid ? resp_rdata : '0;
  assign lsu_err        = lsu_resp_valid && tmo_hit;

endmodule

// File: tb/tb_ysyx_25040105_mem_arb.sv
module tb_ysyx_25040105_mem_arb;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  ysyx_25040105_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit pref_lsu;  // reference: LSU wins a tie when set

  typedef struct {
    bit iv; bit lv; bit e_ir; bit e_lr;
  } gvec_t;

  // own: 0 = IFU expected, 1 = LSU expected, -1 = take it from the reference model
  typedef struct {
    bit iv; bit lv;
    logic [31:0] ia; logic [31:0] la;
    bit lw; logic [31:0] lwd; logic [3:0] lm;
    int rdy; int dly;
    logic [31:0] rd;
    int own;
  } txn_t;

  gvec_t gtab[4];
  txn_t  ttab[8];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
            lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
            mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask};
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic noise_valids(input bit tog);
    ifu_req_valid = tog ? 1'($urandom_range(0, 1)) : 1'b0;
    lsu_req_valid = tog ? 1'($urandom_range(0, 1)) : 1'b0;
    ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom;
  endtask

  task automatic do_reset();
    next_cyc();
    rst = 1'b1;
    idle_inputs();
    next_cyc();
    rst = 1'b0;
    pref_lsu = 1'b1;
  endtask

  // One complete transaction: accept, rdy cycles of backpressure, then a
  // memory response dly+1 cycles after the handshake, or an abort at TMO.
  task automatic run_txn(input txn_t t, input bit tog);
    bit g_lsu, timed_out;
    int e_end;
    logic [31:0] e_addr, e_wdata;
    logic e_wen;
    logic [3:0] e_mask;
    if (t.own >= 0) g_lsu = (t.own == 1);
    else            g_lsu = t.lv && (!t.iv || pref_lsu);
    e_addr  = g_lsu ? t.la : t.ia;
    e_wen   = g_lsu && t.lw;
    e_wdata = g_lsu ? t.lwd : 32'h0;
    e_mask  = g_lsu ? t.lm : 4'h0;
    timed_out = (t.dly + 1) > TMO;
    e_end   = timed_out ? TMO : t.dly + 1;

    next_cyc();
    ifu_req_valid = t.iv; ifu_addr = t.ia;
    lsu_req_valid = t.lv; lsu_addr = t.la; lsu_wen = t.lw; lsu_wdata = t.lwd; lsu_wmask = t.lm;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("grant", {ifu_req_ready, lsu_req_ready}, {t.iv && !g_lsu, g_lsu});

    for (int k = 0; k <= t.rdy; k++) begin
      next_cyc();
      noise_valids(tog);
      mem_req_ready = (k == t.rdy);
      @(negedge clk);
      chk("req_fields",
          {mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready, lsu_req_ready},
          {1'b1, e_addr, e_wen, e_wdata, e_mask, 2'b00});
    end

    for (int j = 1; j <= e_end; j++) begin
      next_cyc();
      noise_valids(tog);
      mem_req_ready  = 1'($urandom_range(0, 1));
      mem_resp_valid = (j == t.dly + 1);
      mem_rdata      = (j == t.dly + 1) ? t.rd : $urandom;
      @(negedge clk);
      chk("wait_quiet", {mem_req_valid, ifu_req_ready, lsu_req_ready}, 3'b000);
      if (j < e_end) begin
        chk("no_early_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
      end else begin
        chk("resp_owner", {ifu_resp_valid, lsu_resp_valid}, {!g_lsu, g_lsu});
        if (g_lsu) chk("lsu_resp", {lsu_rdata, lsu_err}, timed_out ? {32'h0, 1'b1} : {t.rd, 1'b0});
        else       chk("ifu_resp", {ifu_rdata, ifu_err}, timed_out ? {32'h0, 1'b1} : {t.rd, 1'b0});
      end
    end
    pref_lsu = !g_lsu;

    if (timed_out) begin
      for (int j = e_end + 1; j <= t.dly + 1; j++) begin
        next_cyc();
        idle_inputs();
        mem_resp_valid = (j == t.dly + 1);
        mem_rdata = t.rd;
        @(negedge clk);
        chk("late_ignored", {ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready, mem_req_valid}, 5'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t r;
    rst = 1'b1;
    idle_inputs();
    pref_lsu = 1'b1;

    gtab[0] = '{0, 0, 0, 0};
    gtab[1] = '{1, 0, 1, 0};
    gtab[2] = '{0, 1, 0, 1};
    gtab[3] = '{1, 1, 0, 1};

    //            iv lv ia            la            lw lwd           lm    rdy dly rd            own
    ttab[0] = '{1, 1, 32'h80000004, 32'h80001000, 1, 32'hDEADBEEF, 4'hF, 0,  0,  32'h0,        1};
    ttab[1] = '{1, 1, 32'h80000004, 32'h80001004, 0, 32'h0,        4'h0, 0,  0,  32'h00100093, 0};
    ttab[2] = '{1, 1, 32'h80000008, 32'h80001008, 0, 32'h0,        4'h0, 0,  1,  32'hCAFEF00D, 1};
    ttab[3] = '{1, 0, 32'h80000000, 32'h0,        0, 32'h0,        4'h0, 0,  1,  32'h00000413, 0};
    ttab[4] = '{0, 1, 32'h0,        32'h80002000, 1, 32'h12345678, 4'h3, 10, 2,  32'h0,        1};
    ttab[5] = '{1, 0, 32'h80000010, 32'h0,        0, 32'h0,        4'h0, 1,  6,  32'hBADBAD00, 0};
    ttab[6] = '{1, 1, 32'h80000014, 32'h80003000, 0, 32'h0,        4'h0, 0,  3,  32'h55AA55AA, 1};
    ttab[7] = '{0, 1, 32'h0,        32'h80003004, 1, 32'hA5A5A5A5, 4'h5, 0,  0,  32'h0,        1};

    // reset state
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk("outs_in_reset", all_outs(), '0);
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("outs_after_reset", all_outs(), '0);

    // idle grant table; valids dropped before the edge so nothing is accepted
    foreach (gtab[i]) begin
      next_cyc();
      ifu_req_valid = gtab[i].iv;
      lsu_req_valid = gtab[i].lv;
      @(negedge clk);
      chk($sformatf("grant_tab%0d", i), {ifu_req_ready, lsu_req_ready}, {gtab[i].e_ir, gtab[i].e_lr});
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
    end

    // directed transactions, back to back
    foreach (ttab[i]) run_txn(ttab[i], 1'b0);

    // reset while waiting for memory
    do_reset();
    next_cyc();
    ifu_req_valid = 1'b1; ifu_addr = 32'h80000100;
    @(negedge clk);
    chk("rst_seq_accept", ifu_req_ready, 1'b1);
    next_cyc();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    chk("rst_seq_req", {mem_req_valid, mem_addr}, {1'b1, 32'h80000100});
    next_cyc();
    mem_req_ready = 1'b0; rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h00001234;
    @(negedge clk);
    chk("rst_no_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outs_zero", all_outs(), '0);
    pref_lsu = 1'b1;
    next_cyc();
    idle_inputs();
    r = '{1, 0, 32'h80000200, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h0000F00D, 0};
    run_txn(r, 1'b0);

    // randomized traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      r.iv  = 1'($urandom_range(0, 1));
      r.lv  = r.iv ? 1'($urandom_range(0, 1)) : 1'b1;
      r.ia  = $urandom; r.la = $urandom;
      r.lw  = 1'($urandom_range(0, 1));
      r.lwd = $urandom; r.lm = 4'($urandom_range(0, 15));
      r.rdy = $urandom_range(0, 3);
      r.dly = $urandom_range(0, 6);
      r.rd  = $urandom;
      r.own = -1;
      run_txn(r, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        next_cyc();
        idle_inputs();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25040105_mem_arb.md
YSYX_25040105_MEM_ARB -- requirements
Module: ysyx_25040105_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width.
REQ-002 SHALL have parameter DATA_W, 32, data width; wmask width = DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, 255, max WAIT cycles before abort (1..65535).
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 ifu_req_valid/ifu_req_ready  in/out  1/1  IFU read request handshake.
REQ-008 ifu_addr  in  ADDR_W  fetch address.
REQ-009 ifu_resp_valid/ifu_rdata/ifu_err  out  1/DATA_W/1  IFU response; rdata and err valid only while resp_valid.
REQ-010 lsu_req_valid/lsu_req_ready  in/out  1/1  LSU request handshake.
REQ-011 lsu_addr/lsu_wen/lsu_wdata/lsu_wmask  in  ADDR_W/1/DATA_W/DATA_W/8  LSU address, write enable, write data, byte mask.
REQ-012 lsu_resp_valid/lsu_rdata/lsu_err  out  1/DATA_W/1  LSU response; writes also get a response.
REQ-013 mem_req_valid/mem_req_ready  out/in  1/1  memory request handshake.
REQ-014 mem_addr/mem_wen/mem_wdata/mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  registered request fields.
REQ-015 mem_resp_valid/mem_rdata  in  1/DATA_W  memory response, one-cycle pulse.

Function
REQ-016 SHALL implement FSM IDLE -> REQ -> WAIT -> IDLE; one outstanding transaction maximum.
REQ-017 IDLE: grant exactly one valid requester; ready asserted only to the granted one, combinationally from valids and rr pointer.
REQ-018 Both valid: grant the requester not served last (rr); rr = LSU-preferred after reset; only one valid: grant it.
REQ-019 On accept (valid & ready): latch owner, addr, wen, wdata, wmask; IFU forces wen=0, wmask=0; go to REQ next cycle.
REQ-020 REQ: mem_req_valid=1 with latched fields held stable until mem_req_ready; on handshake go to WAIT, clear timer.
REQ-021 WAIT: on mem_resp_valid, pulse owner resp_valid one cycle with rdata=mem_rdata, err=0; update rr to owner; go to IDLE.
REQ-022 WAIT: timer increments each cycle; at timer==TIMEOUT without response, pulse owner resp_valid with rdata=0, err=1; go to IDLE.
REQ-023 Response and timeout in same cycle: response wins, err=0.
REQ-024 mem_resp_valid outside WAIT SHALL be ignored (late response after abort).
REQ-025 Requester ready=0 in REQ and WAIT; requester valids may toggle freely there without effect.
REQ-026 Non-owner resp_valid SHALL stay 0; at most one resp_valid high per cycle.
REQ-027 Minimum turnaround: accept N, mem_req_valid N+1, earliest resp N+2, next accept N+3.
REQ-028 REQ state has no timeout (memory backpressure unbounded).

Reset
REQ-029 On rst: state=IDLE, rr=LSU-preferred, timer=0, latched fields=0.
REQ-030 Reset values: all ready/valid/err outputs 0, all data/addr/mask outputs 0.
REQ-031 rst mid-transaction SHALL abandon it without any response pulse; memory response arriving after reset ignored.

Structure
REQ-032 Shared package ysyx_25040105_pkg SHALL hold FSM state encoding, owner encoding (OWN_IFU, OWN_LSU), default ADDR_W/DATA_W.
REQ-033 One sub-module ysyx_25040105_rr_arb2 (2-way round-robin grant plus pointer) is natural; FSM, latch and timer stay in top.

Verification
REQ-034 IFU only, addr 0x80000000, mem_req_ready=1, resp after 1 cycle rdata 0x00000413 -> ifu_resp_valid once, rdata 0x00000413, err=0, mem_wen=0.
REQ-035 IFU and LSU valid together after reset, LSU write 0x80001000 data 0xDEADBEEF mask 0xF -> LSU served first, then IFU; third contention serves LSU again.
REQ-036 mem_req_ready low 10 cycles -> mem_addr/wdata/wmask stable throughout, no timeout, single request handshake.
REQ-037 TIMEOUT=4, no memory response -> owner resp_valid with err=1, rdata=0 exactly 4 cycles after request handshake; late mem_resp_valid ignored.
REQ-038 rst asserted during WAIT -> all outputs 0 next cycle, no resp pulse, fresh IFU request completes normally.
REQ-039 Response arriving on the cycle timer==TIMEOUT -> err=0, rdata=mem_rdata.
